// File: rtl/iexecute.sv
//------------------------------------------------------------------------------
// Module   : iexecute
// Brief    : EX stage with ALU control decode, ALU, branch-target adder and
//            a single registered EX/MEM boundary.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

// Maps the decode-stage ALU class and funct field onto a 3-bit ALU select.
module alu_control (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_sel
);

  localparam logic [2:0] c_sel_and  = 3'b000;
  localparam logic [2:0] c_sel_or   = 3'b001;
  localparam logic [2:0] c_sel_add  = 3'b010;
  localparam logic [2:0] c_sel_none = 3'b011;
  localparam logic [2:0] c_sel_sub  = 3'b110;
  localparam logic [2:0] c_sel_slt  = 3'b111;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  always_comb begin
    alu_sel = c_sel_none;
    case (aluop)
      2'b00: alu_sel = c_sel_add;
      2'b01: alu_sel = c_sel_sub;
      2'b10: begin
        case (funct)
          c_fn_add: alu_sel = c_sel_add;
          c_fn_sub: alu_sel = c_sel_sub;
          c_fn_and: alu_sel = c_sel_and;
          c_fn_or:  alu_sel = c_sel_or;
          c_fn_slt: alu_sel = c_sel_slt;
          default:  alu_sel = c_sel_none;
        endcase
      end
      default: alu_sel = c_sel_none;
    endcase
  end

endmodule

// 32-bit ALU; unrecognised selects produce zero rather than a stale value.
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  output logic [31:0] result,
  output logic        zero
);

  localparam logic [2:0] c_sel_and = 3'b000;
  localparam logic [2:0] c_sel_or  = 3'b001;
  localparam logic [2:0] c_sel_add = 3'b010;
  localparam logic [2:0] c_sel_sub = 3'b110;
  localparam logic [2:0] c_sel_slt = 3'b111;

  always_comb begin
    result = 32'h0;
    case (sel)
      c_sel_add: result = a + b;
      c_sel_sub: result = a - b;
      c_sel_and: result = a & b;
      c_sel_or:  result = a | b;
      c_sel_slt: result = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default:   result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// EX stage top: operand/destination muxing plus the EX/MEM pipeline register.
module iexecute (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic [1:0]  wb_ctlout,
  output logic        branch,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  five_bit_muxout
);

  logic [31:0] w_operand_b;
  logic [2:0]  w_alu_sel;
  logic [31:0] w_alu_result;
  logic        w_alu_zero;
  logic [31:0] w_branch_target;
  logic [4:0]  w_dest_reg;

  logic [1:0]  r_wb_ctl;
  logic [2:0]  r_m_ctl;
  logic [31:0] r_add_result;
  logic        r_zero;
  logic [31:0] r_alu_result;
  logic [31:0] r_rdata2;
  logic [4:0]  r_dest_reg;

  assign w_operand_b = alusrc ? s_extend : rdata2;
  assign w_dest_reg  = regdst ? instr_1511 : instr_2016;
  // Word-addressed PC: the offset is added without a left shift.
  assign w_branch_target = npc + s_extend;

  alu_control u_alu_control (
    .aluop   (aluop),
    .funct   (s_extend[5:0]),
    .alu_sel (w_alu_sel)
  );

  alu u_alu (
    .a      (rdata1),
    .b      (w_operand_b),
    .sel    (w_alu_sel),
    .result (w_alu_result),
    .zero   (w_alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_ctl     <= 2'b00;
      r_m_ctl      <= 3'b000;
      r_add_result <= 32'h0;
      r_zero       <= 1'b0;
      r_alu_result <= 32'h0;
      r_rdata2     <= 32'h0;
      r_dest_reg   <= 5'd0;
    end else begin
      r_wb_ctl     <= wb_ctl;
      r_m_ctl      <= m_ctl;
      r_add_result <= w_branch_target;
      r_zero       <= w_alu_zero;
      r_alu_result <= w_alu_result;
      r_rdata2     <= rdata2;
      r_dest_reg   <= w_dest_reg;
    end
  end

  assign wb_ctlout       = r_wb_ctl;
  assign branch          = r_m_ctl[2];
  assign memread         = r_m_ctl[1];
  assign memwrite        = r_m_ctl[0];
  assign add_result      = r_add_result;
  assign zero            = r_zero;
  assign alu_result      = r_alu_result;
  assign rdata2out       = r_rdata2;
  assign five_bit_muxout = r_dest_reg;

endmodule

`default_nettype wire
